pipe_reg_skid: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB). Carries an opaque payload bus between two pipeline stages.
- Uses a valid/ready handshake in place of the stall_ctrl bit pair.
- Optional 2-entry skid buffer, so up_ready is a registered signal and does not depend on dn_ready.
- Keeps flush, NOP-bubble insertion, and a scratch feedback path for multi-cycle execute operations (mult/div accumulator and cycle count).

---
 rtl/pipe_reg_skid.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - valid/ready inter-stage pipeline register with optional skid entry, flush and scratch feedback
module pipe_reg_skid #(
  parameter int                DATA_W      = 128,
  parameter int                SCRATCH_W   = 66,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
  parameter bit                SKID        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [DATA_W-1:0]    up_data,
  input  logic                 up_busy,
  input  logic [SCRATCH_W-1:0] scratch_i,
  output logic [SCRATCH_W-1:0] scratch_o,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [DATA_W-1:0]    dn_data,
  output logic [1:0]           occupancy
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic              accept;
  logic              emit;

  assign accept = up_valid & up_ready;
  assign emit   = main_valid & dn_ready;

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_data;
      logic              load_main;

      // Ready depends only on held state, never on dn_ready.
      assign up_ready  = rst & ~skid_valid;
      assign load_main = ~main_valid | emit;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= NOP_PAYLOAD;
          skid_valid <= 1'b0;
          skid_data  <= NOP_PAYLOAD;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= NOP_PAYLOAD;
          skid_valid <= 1'b0;
          skid_data  <= NOP_PAYLOAD;
        end else if (load_main) begin
          if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= accept;
            skid_data  <= accept ? up_data : NOP_PAYLOAD;
          end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= up_data;
          end else begin
            main_valid <= 1'b0;
            main_data  <= NOP_PAYLOAD;
          end
        end else if (accept) begin
          skid_valid <= 1'b1;
          skid_data  <= up_data;
        end
      end
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign up_ready   = rst & (~main_valid | dn_ready);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= NOP_PAYLOAD;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= NOP_PAYLOAD;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_data  <= up_data;
        end else if (emit) begin
          main_valid <= 1'b0;
          main_data  <= NOP_PAYLOAD;
        end
      end
    end
  endgenerate

  // Scratch ignores dn_ready so a downstream stall cannot disturb a multi-cycle op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch_o <= '0;
    end else if (flush) begin
      scratch_o <= '0;
    end else if (up_busy) begin
      scratch_o <= scratch_i;
    end else begin
      scratch_o <= '0;
    end
  end

  assign dn_valid  = main_valid;
  assign dn_data   = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
